// File: rtl/nv_ram_rwsp_256x11_fifo_ctrl_pkg.sv
// Shared sizing constants and pointer helper for the 256x11 small-RAM FIFO.
package nv_ram_rwsp_256x11_fifo_ctrl_pkg;

    localparam int FIFO_DEPTH = 256;
    localparam int FIFO_AW    = 8;
    localparam int FIFO_DW    = 11;

    // DEPTH is a power of two, so the natural overflow gives the 255->0 wrap.
    function automatic logic [FIFO_AW-1:0] ptr_inc(input logic [FIFO_AW-1:0] ptr);
        return ptr + {{(FIFO_AW-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/nv_ram_rwsp_256x11.sv
// 256x11 single-port-per-direction RAM with two-stage registered read:
// the read address is captured on re, the data is captured on ore.
module nv_ram_rwsp_256x11
    import nv_ram_rwsp_256x11_fifo_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               re,
    input  logic               we,
    input  logic               ore,
    input  logic [FIFO_AW-1:0] ra,
    input  logic [FIFO_AW-1:0] wa,
    input  logic [FIFO_DW-1:0] di,
    output logic [FIFO_DW-1:0] dout,
    input  logic [31:0]        pwrbus_ram_pd
);

    logic [FIFO_DW-1:0] mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] ra_d;
    logic [FIFO_DW-1:0] dout_r;

    // Storage is deliberately not reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= di;
        end
        if (re) begin
            ra_d <= ra;
        end
        if (ore) begin
            dout_r <= mem[ra_d];
        end
    end

    assign dout = dout_r;

    // Power-bus controls have no behavioural effect in this model.
    logic unused_pwrbus;
    assign unused_pwrbus = ^pwrbus_ram_pd;

endmodule

// File: rtl/nv_ram_rwsp_256x11_fifo_ctrl.sv
// Valid/ready FIFO controller around one nv_ram_rwsp_256x11; the RAM's
// two-stage read (ra_d, dout_r) forms a stallable two-entry pop pipeline.
module nv_ram_rwsp_256x11_fifo_ctrl
    import nv_ram_rwsp_256x11_fifo_ctrl_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH,
    parameter int AW    = FIFO_AW,
    parameter int DW    = FIFO_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_valid,
    output logic          push_ready,
    input  logic [DW-1:0] push_data,
    output logic          pop_valid,
    input  logic          pop_ready,
    output logic [DW-1:0] pop_data,
    output logic [AW:0]   count,
    output logic          idle,
    input  logic [31:0]   pwrbus_ram_pd
);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   ram_used_q, ram_used_d;
    logic          s1_v_q, s1_v_d;
    logic          s2_v_q, s2_v_d;

    logic          push_fire;
    logic          ram_re;
    logic          ram_ore;

    always_comb begin
        push_ready = (ram_used_q < (AW+1)'(DEPTH));
        push_fire  = push_valid & push_ready;

        ram_ore = s1_v_q & (~s2_v_q | pop_ready);
        // ram_used still counts the entry sitting under ra_d, so exclude it
        // when deciding whether an unread entry exists.
        ram_re  = (ram_used_q > {{AW{1'b0}}, s1_v_q}) & (~s1_v_q | ram_ore);

        wr_ptr_d = push_fire ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = ram_re ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        s1_v_d   = ram_re | (s1_v_q & ~ram_ore);
        s2_v_d   = ram_ore | (s2_v_q & ~pop_ready);

        // A slot is released only once its data has moved into dout_r.
        ram_used_d = ram_used_q;
        case ({push_fire, ram_ore})
            2'b10:   ram_used_d = ram_used_q + {{AW{1'b0}}, 1'b1};
            2'b01:   ram_used_d = ram_used_q - {{AW{1'b0}}, 1'b1};
            default: ram_used_d = ram_used_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            ram_used_q <= '0;
            s1_v_q     <= 1'b0;
            s2_v_q     <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            ram_used_q <= ram_used_d;
            s1_v_q     <= s1_v_d;
            s2_v_q     <= s2_v_d;
        end
    end

    assign pop_valid = s2_v_q;
    assign count     = ram_used_q + {{AW{1'b0}}, s2_v_q};
    assign idle      = (count == '0) & ~s1_v_q;

    nv_ram_rwsp_256x11 u_ram (
        .clk           (clk),
        .re            (ram_re),
        .we            (push_fire),
        .ore           (ram_ore),
        .ra            (rd_ptr_q),
        .wa            (wr_ptr_q),
        .di            (push_data),
        .dout          (pop_data),
        .pwrbus_ram_pd (pwrbus_ram_pd)
    );

endmodule

// File: tb/tb_nv_ram_rwsp_256x11_fifo_ctrl.sv
// Directed and randomised checks of the 256x11 FIFO controller against a
// queue scoreboard of accepted pushes.
module tb_nv_ram_rwsp_256x11_fifo_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        push_valid;
    logic        push_ready;
    logic [10:0] push_data;
    logic        pop_valid;
    logic        pop_ready;
    logic [10:0] pop_data;
    logic [8:0]  count;
    logic        idle;
    logic [31:0] pwrbus_ram_pd;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int last_push_cyc = 0;
    int last_pop_cyc = 0;
    int pushes_since_rst = 0;
    bit pushed = 1'b0;
    logic [10:0] sb[$];

    nv_ram_rwsp_256x11_fifo_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .push_valid    (push_valid),
        .push_ready    (push_ready),
        .push_data     (push_data),
        .pop_valid     (pop_valid),
        .pop_ready     (pop_ready),
        .pop_data      (pop_data),
        .count         (count),
        .idle          (idle),
        .pwrbus_ram_pd (pwrbus_ram_pd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample outputs at negedge, update scoreboard, advance past posedge.
    task automatic cycle();
        bit do_rst;
        logic [10:0] exp;
        @(negedge clk);
        do_rst = rst;
        pushed = 1'b0;
        if (!do_rst) begin
            chk("count", 32'(count), 32'(sb.size()));
            chk("idle", 32'(idle), 32'(sb.size() == 0));
            if (pop_valid && pop_ready) begin
                checks++;
                assert (sb.size() > 0) else begin
                    errors++;
                    $error("FAIL pop_underflow: observed=%0h expected=none", pop_data);
                end
                if (sb.size() > 0) begin
                    exp = sb.pop_front();
                    chk("pop_data", 32'(pop_data), 32'(exp));
                    $display("cyc %0d pop  0x%03h", cyc, pop_data);
                end
                last_pop_cyc = cyc;
            end
            if (push_valid && push_ready) begin
                sb.push_back(push_data);
                pushes_since_rst++;
                last_push_cyc = cyc;
                pushed = 1'b1;
                $display("cyc %0d push 0x%03h", cyc, push_data);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (do_rst) begin
            sb.delete();
            pushes_since_rst = 0;
        end
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        pop_ready = 1'b1;
        while (sb.size() > 0 && n < budget) begin
            cycle();
            n++;
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int sent;
        int n;
        logic [10:0] held;

        rst = 1'b1;
        push_valid = 1'b0;
        push_data = '0;
        pop_ready = 1'b0;
        pwrbus_ram_pd = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        chk("rst_pop_valid", 32'(pop_valid), 32'd0);
        chk("rst_push_ready", 32'(push_ready), 32'd1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_idle", 32'(idle), 32'd1);

        // Single push latency
        pop_ready = 1'b1;
        push_valid = 1'b1;
        push_data = 11'h5A5;
        cycle();
        push_valid = 1'b0;
        chk("single_count", 32'(count), 32'd1);
        drain(10);
        chk("single_latency", 32'(last_pop_cyc - last_push_cyc), 32'd3);

        // Fill to 257 with consumer stalled
        pop_ready = 1'b0;
        for (int i = 0; i < 257; i++) begin
            push_valid = 1'b1;
            push_data = 11'(i);
            chk("fill_ready", 32'(push_ready), 32'd1);
            cycle();
        end
        chk("full_ready", 32'(push_ready), 32'd0);
        chk("full_count", 32'(count), 32'h101);
        push_data = 11'h7FF;
        repeat (5) cycle();
        push_valid = 1'b0;
        chk("full_count_hold", 32'(count), 32'h101);
        drain(400);

        // Stall hold
        pop_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_valid = 1'b1;
            push_data = 11'h300 + 11'(i);
            cycle();
        end
        push_valid = 1'b0;
        repeat (3) cycle();
        chk("stall_valid", 32'(pop_valid), 32'd1);
        chk("stall_s1", 32'(dut.s1_v_q), 32'd1);
        held = pop_data;
        chk("stall_head", 32'(held), 32'h300);
        for (int i = 0; i < 10; i++) begin
            chk("stall_data", 32'(pop_data), 32'(held));
            chk("stall_re", 32'(dut.ram_re), 32'd0);
            chk("stall_ore", 32'(dut.ram_ore), 32'd0);
            cycle();
        end
        drain(20);

        // Reset mid-stream with a read in flight
        pop_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_valid = 1'b1;
            push_data = 11'h050 + 11'(i);
            cycle();
        end
        push_valid = 1'b0;
        repeat (3) cycle();
        chk("mid_count", 32'(count), 32'd5);
        chk("mid_s1", 32'(dut.s1_v_q), 32'd1);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_pop_valid", 32'(pop_valid), 32'd0);
        chk("mid_rst_idle", 32'(idle), 32'd1);
        pop_ready = 1'b1;
        push_valid = 1'b1;
        push_data = 11'h123;
        cycle();
        push_valid = 1'b0;
        drain(10);

        // Random traffic across pointer wrap
        sent = 0;
        n = 0;
        while ((sent < 600 || sb.size() > 0) && n < 20000) begin
            push_valid = (sent < 600) && ($urandom_range(0, 3) != 0);
            push_data = 11'(sent);
            pop_ready = ($urandom_range(0, 2) != 0);
            cycle();
            if (pushed) sent++;
            n++;
        end
        push_valid = 1'b0;
        chk("rand_sent", 32'(sent), 32'd600);
        chk("rand_empty", 32'(sb.size()), 32'd0);
        chk("rand_wr_ptr", 32'(dut.wr_ptr_q), 32'(pushes_since_rst % 256));
        chk("rand_rd_ptr", 32'(dut.rd_ptr_q), 32'(pushes_since_rst % 256));
        repeat (3) cycle();
        chk("rand_idle", 32'(idle), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
